pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of the datapath payload (operands, immediate, PC, register indices).
REQ-002 SHALL have parameter CTRL_W, default 10, width of the control payload (ALU, branch, memory and writeback control bits).
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (branch/jump redirect).
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_ctrl  in  CTRL_W  control payload in.
- in_data  in  DATA_W  datapath payload in.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control payload out.
- out_data  out  DATA_W  datapath payload out.
- stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-005 SHALL accept an entry when in_valid=1 and in_ready=1; SHALL deliver one when out_valid=1 and out_ready=1.
REQ-006 SHALL give 1-cycle latency: an entry accepted into an empty stage appears on out_* the next cycle.
REQ-007 SHALL sustain one transfer per cycle while out_ready=1.
REQ-008 SHALL drive out_ctrl, out_data and out_valid directly from registers (no input-to-output combinational path).
REQ-009 SHALL force out_ctrl to all-zero whenever out_valid=0 (bubble = NOP control); out_data then holds its last value.
REQ-010 SHALL, when out_valid=1 and out_ready=0, hold out_ctrl and out_data stable until delivery.
REQ-011 SHALL never drop, duplicate or reorder accepted entries.
REQ-012 SHALL, on flush=1, clear every held entry, so out_valid=0 next cycle; any entry accepted in that cycle is discarded, and in_ready returns to 1 next cycle.
REQ-013 SHALL give rst priority over flush, and flush priority over accept/deliver.
REQ-014 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; flush does not clear it.

Reset
REQ-015 SHALL, while rst=1 at a clk edge, clear all entries and stall_cnt.
REQ-016 SHALL, during and after reset, present out_valid=0, out_ctrl=0, out_data=0 and stall_cnt=0, with in_ready=1 from the first cycle after reset.
REQ-017 SHALL, when rst is asserted mid-stall, discard all held entries with no delivery.

Configuration
REQ-018 SHALL, with macro PIPE_STAGE_SKID_EN defined, implement a two-entry skid buffer (main plus skid register):
- in_ready is registered, equal to NOT skid_valid.
- An entry accepted while main is full and out_ready=0 goes to the skid register.
- When main drains, main loads from skid before new input.
- Up to 2 entries held; full throughput with no ready combinational path.
REQ-019 SHALL, with PIPE_STAGE_SKID_EN undefined, implement a single register:
- in_ready = out_ready OR NOT out_valid (combinational).
- At most 1 entry held.
- All other requirements unchanged.

Verification (DATA_W=32, CTRL_W=4, CNT_W=4)
REQ-020 SHALL cover: reset then idle -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
REQ-021 SHALL cover: stream data 1..8, ctrl 0xA, out_ready=1 -> out_data 1..8 in order, each one cycle after input, no gaps.
REQ-022 SHALL cover: hold out_ready=0 for 20 cycles with an entry held -> out_* stable, stall_cnt saturates at 15; in_ready falls after 2 accepts with SKID_EN, after 1 without.
REQ-023 SHALL cover: two entries held (SKID_EN), flush=1 with in_valid=1 data 0x55 -> next cycle out_valid=0, out_ctrl=0, 0x55 never emitted, in_ready=1.
REQ-024 SHALL cover: random in_valid/out_ready at 50% for 1000 entries -> scoreboard exact in-order match, and out_ctrl=0 on every cycle with out_valid=0.
REQ-025 SHALL cover: rst=1 and flush=1 in the same cycle mid-stall -> reset values (REQ-016) next cycle, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, NOP control on bubbles, saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = ~skid_valid;

  // Main refills from skid before taking new input so order is kept; main_ctrl is zeroed whenever main empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = out_ready | ~main_valid;

  // Single entry: load on accept, otherwise drop to a bubble with NOP control once delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end else if (in_ready) begin
      if (in_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
      end
    end
  end
`endif

  // Counts back-pressured cycles; survives flush, only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DATA_W=32, CTRL_W=4, CNT_W=4); follows PIPE_STAGE_SKID_EN like the DUT.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] d;
  } entry_t;

  typedef struct {
    bit          iv;
    logic [31:0] d;
    bit          orr;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_ready;
    int          exp_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = 4'h0;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_ctrl;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt;

  entry_t model_q[$];
  int     model_stall = 0;
  int     accepted = 0;
  int     tests_run = 0;
  int     tests_failed = 0;
  vec_t   stall_vec[22];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
`ifdef PIPE_STAGE_SKID_EN
    return model_q.size() < 2;
`else
    return out_ready || (model_q.size() == 0);
`endif
  endfunction

  task automatic applyStimulus(input bit iv, input logic [3:0] c, input logic [31:0] d,
                               input bit orr, input bit fl, input bit rs);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = orr;
    flush     = fl;
    rst       = rs;
    #1;
  endtask

  task automatic checkOutput();
    bit mv;
    mv = model_q.size() > 0;
    check_val("out_valid", 32'(out_valid), 32'(mv));
    check_val("out_ctrl", 32'(out_ctrl), mv ? 32'(model_q[0].c) : 32'h0);
    if (mv) check_val("out_data", out_data, model_q[0].d);
    if (!out_valid) check_val("bubble_ctrl", 32'(out_ctrl), 32'h0);
    check_val("in_ready", 32'(in_ready), 32'(model_ready()));
    check_val("stall_cnt", 32'(stall_cnt), 32'(model_stall));
  endtask

  task automatic step_clock();
    bit     mv, acc, del, stl;
    entry_t e;
    mv  = model_q.size() > 0;
    acc = in_valid && model_ready();
    del = mv && out_ready;
    stl = mv && !out_ready;
    e.c = in_ctrl;
    e.d = in_data;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_stall = 0;
    end else begin
      if (stl && model_stall < 15) model_stall++;
      if (flush) begin
        model_q.delete();
      end else begin
        if (del) void'(model_q.pop_front());
        if (acc) begin
          model_q.push_back(e);
          accepted++;
        end
      end
    end
    #1;
  endtask

  task automatic cycle(input bit iv, input logic [3:0] c, input logic [31:0] d,
                       input bit orr, input bit fl, input bit rs);
    applyStimulus(iv, c, d, orr, fl, rs);
    checkOutput();
    step_clock();
  endtask

  initial begin
    int base;
    int cyc;

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0);
    check_val("rst_out_valid", 32'(out_valid), 32'h0);
    check_val("rst_out_ctrl", 32'(out_ctrl), 32'h0);
    check_val("rst_out_data", out_data, 32'h0);
    check_val("rst_in_ready", 32'(in_ready), 32'h1);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    step_clock();
    cycle(0, 4'h0, 32'h0, 1, 0, 0);

    // stream 1..8 with out_ready held high
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(k < 8, 4'hA, 32'(k + 1), 1, 0, 0);
      if (k > 0) begin
        check_val("stream_valid", 32'(out_valid), 32'h1);
        check_val("stream_data", out_data, 32'(k));
        check_val("stream_ctrl", 32'(out_ctrl), 32'hA);
      end
      checkOutput();
      step_clock();
    end
    repeat (2) cycle(0, 4'h0, 32'h0, 1, 0, 0);

    // back-pressure table: out_ready low, stall_cnt saturates at 15
    for (int k = 0; k < 22; k++) begin
      stall_vec[k].iv        = (k < 21);
      stall_vec[k].d         = 32'h100 + 32'(k);
      stall_vec[k].orr       = 1'b0;
      stall_vec[k].exp_valid = (k > 0);
      stall_vec[k].exp_data  = 32'h100;
`ifdef PIPE_STAGE_SKID_EN
      stall_vec[k].exp_ready = (k <= 1);
`else
      stall_vec[k].exp_ready = (k == 0);
`endif
      stall_vec[k].exp_stall = (k == 0) ? 0 : ((k - 1 > 15) ? 15 : k - 1);
    end
    for (int k = 0; k < 22; k++) begin
      applyStimulus(stall_vec[k].iv, 4'h3, stall_vec[k].d, stall_vec[k].orr, 0, 0);
      check_val("tbl_valid", 32'(out_valid), 32'(stall_vec[k].exp_valid));
      if (stall_vec[k].exp_valid) begin
        check_val("tbl_data", out_data, stall_vec[k].exp_data);
        check_val("tbl_ctrl", 32'(out_ctrl), 32'h3);
      end
      check_val("tbl_ready", 32'(in_ready), 32'(stall_vec[k].exp_ready));
      check_val("tbl_stall", 32'(stall_cnt), 32'(stall_vec[k].exp_stall));
      checkOutput();
      step_clock();
    end
    repeat (4) cycle(0, 4'h0, 32'h0, 1, 0, 0);

    // flush with entries held; 0x55 offered in the flush cycle must never emerge
    cycle(1, 4'h5, 32'h21, 0, 0, 0);
`ifdef PIPE_STAGE_SKID_EN
    cycle(1, 4'h6, 32'h22, 0, 0, 0);
    cycle(1, 4'h7, 32'h55, 0, 1, 0);
`else
    cycle(1, 4'h7, 32'h55, 1, 1, 0);
`endif
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0);
    check_val("flush_valid", 32'(out_valid), 32'h0);
    check_val("flush_ctrl", 32'(out_ctrl), 32'h0);
    check_val("flush_ready", 32'(in_ready), 32'h1);
    checkOutput();
    step_clock();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 4'h0, 32'h0, 1, 0, 0);
      check_val("flush_discard", 32'(out_valid && (out_data == 32'h55)), 32'h0);
      checkOutput();
      step_clock();
    end

    // random traffic, 1000 entries through the scoreboard
    base = accepted;
    cyc = 0;
    while ((accepted - base) < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 0, 0);
      cyc++;
    end
    check_val("random_accepts", 32'(accepted - base), 32'd1000);
    cyc = 0;
    while (model_q.size() > 0 && cyc < 10) begin
      cycle(0, 4'h0, 32'h0, 1, 0, 0);
      cyc++;
    end
    check_val("random_drained", 32'(model_q.size()), 32'h0);
    cycle(0, 4'h0, 32'h0, 1, 0, 0);

    // reset and flush together mid-stall
    cycle(1, 4'h9, 32'h77, 0, 0, 0);
    cycle(1, 4'h9, 32'h78, 0, 0, 0);
    cycle(1, 4'h9, 32'h79, 0, 1, 1);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0);
    check_val("rstfl_valid", 32'(out_valid), 32'h0);
    check_val("rstfl_ctrl", 32'(out_ctrl), 32'h0);
    check_val("rstfl_data", out_data, 32'h0);
    check_val("rstfl_stall", 32'(stall_cnt), 32'h0);
    check_val("rstfl_ready", 32'(in_ready), 32'h1);
    checkOutput();
    step_clock();
    repeat (3) cycle(0, 4'h0, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
